// File: rtl/lsq_index_freelist.sv
// Circular free-list of LSQ entry indices: commit releases (push), dispatch allocates (pop); preloaded on reset/flush.
// Latency: popped index is registered (1 cycle); PreOut shows the head slot combinationally in the request cycle.
// Backpressure: none; rejected pushes/pops only raise PushErr/PopErr. Build option LSQ_FREELIST_CHKPT_EN adds head checkpoint/recover.
module lsq_index_freelist #(
    parameter int WIDTH     = 4,
    parameter int DEPTH     = 4,
    parameter int INIT_BASE = 0,
    parameter int INIT_STEP = 4,
    parameter int INIT_FULL = 1,
    parameter int AE_THRESH = 1
) (
    input  logic                         Clk,
    input  logic                         Rest,
    input  logic                         Rable,
    output logic [WIDTH-1:0]             Dout,
    output logic                         DoutValid,
    output logic [WIDTH-1:0]             PreOut,
    input  logic                         Wable,
    input  logic [WIDTH-1:0]             Din,
    input  logic                         Clean,
    output logic                         Full,
    output logic                         Empty,
    output logic [$clog2(DEPTH+1)-1:0]   Count,
    output logic                         AlmostEmpty,
    output logic                         PushErr,
    output logic                         PopErr
`ifdef LSQ_FREELIST_CHKPT_EN
    ,
    input  logic                         Chkpt,
    input  logic                         Recover
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] INIT_CNT = (INIT_FULL != 0) ? CW'(DEPTH) : '0;
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_THRESH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;

    logic             pop_ok;
    logic             push_ok;
    logic             rec;
    logic [CW-1:0]    count_nxt;

    // Preload image: arithmetic sequence truncated to the index width.
    function automatic logic [WIDTH-1:0] preload(input int i);
        return WIDTH'(INIT_BASE + i * INIT_STEP);
    endfunction

    // Explicit wrap so non-power-of-two depths cycle through 0..DEPTH-1 only.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

`ifdef LSQ_FREELIST_CHKPT_EN
    logic [PW-1:0]    snap_head;
    logic [CW-1:0]    snap_count;
    logic [CW-1:0]    snap_pushes;
    logic [CW:0]      rec_sum;
    logic [CW-1:0]    rec_count;

    assign rec = Recover;

    // Restored occupancy: snapshot count plus releases since the snapshot, capped at DEPTH.
    always_comb begin
        rec_sum   = {1'b0, snap_count} + {1'b0, snap_pushes};
        rec_count = (rec_sum > {1'b0, FULL_CNT}) ? FULL_CNT : rec_sum[CW-1:0];
    end
`else
    assign rec = 1'b0;
`endif

    // Acceptance: a push into a full list is allowed only when a pop frees a slot in the same cycle.
    always_comb begin
        pop_ok  = Rable && (count != '0) && !rec;
        push_ok = Wable && ((count != FULL_CNT) || pop_ok) && !rec;
        case ({push_ok, pop_ok})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Main state: reset/flush restore, then recover, then normal push/pop.
    always_ff @(posedge Clk) begin
        if (!Rest || Clean) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= preload(i);
            end
            head      <= '0;
            tail      <= '0;
            count     <= INIT_CNT;
            DoutValid <= 1'b0;
            PushErr   <= 1'b0;
            PopErr    <= 1'b0;
            if (!Rest) begin
                Dout <= '0;
            end
        end else if (rec) begin
`ifdef LSQ_FREELIST_CHKPT_EN
            head  <= snap_head;
            count <= rec_count;
`endif
            DoutValid <= 1'b0;
            PushErr   <= 1'b0;
            PopErr    <= 1'b0;
        end else begin
            if (pop_ok) begin
                Dout <= mem[head];
                head <= ptr_inc(head);
            end
            if (push_ok) begin
                mem[tail] <= Din;
                tail      <= ptr_inc(tail);
            end
            count     <= count_nxt;
            DoutValid <= pop_ok;
            PopErr    <= Rable && !pop_ok;
            PushErr   <= Wable && !push_ok;
        end
    end

`ifdef LSQ_FREELIST_CHKPT_EN
    // Snapshot of head/count (pre-pop) and a saturating count of releases since the snapshot.
    always_ff @(posedge Clk) begin
        if (!Rest) begin
            snap_head   <= '0;
            snap_count  <= '0;
            snap_pushes <= '0;
        end else if (!Clean && !rec) begin
            if (Chkpt) begin
                snap_head   <= head;
                snap_count  <= count;
                snap_pushes <= push_ok ? CW'(1) : '0;
            end else if (push_ok && snap_pushes != FULL_CNT) begin
                snap_pushes <= snap_pushes + CW'(1);
            end
        end
    end
`endif

    assign PreOut      = mem[head];
    assign Count       = count;
    assign Full        = (count == FULL_CNT);
    assign Empty       = (count == '0);
    assign AlmostEmpty = (count <= AE_CNT);

endmodule

// File: tb/tb_lsq_index_freelist.sv
// Directed bench for lsq_index_freelist: default DEPTH=4 full-preload instance and a DEPTH=3 empty-preload instance.
// Inputs are driven 1ns after the rising edge; outputs are sampled at the same point.
// Expected values are hand-computed constants.
module tb_lsq_index_freelist;

    logic       Clk;
    logic       Rest;

    // Instance a: defaults (DEPTH=4, base 0, step 4, starts full)
    logic       Rable, Wable, Clean;
    logic [3:0] Din, Dout, PreOut;
    logic       DoutValid, Full, Empty, AlmostEmpty, PushErr, PopErr;
    logic [2:0] Count;
`ifdef LSQ_FREELIST_CHKPT_EN
    logic       Chkpt, Recover;
`endif

    // Instance b: DEPTH=3, starts empty
    logic       b_rable, b_wable, b_clean;
    logic [3:0] b_din, b_dout, b_preout;
    logic       b_doutvalid, b_full, b_empty, b_ae, b_pusherr, b_poperr;
    logic [1:0] b_count;
`ifdef LSQ_FREELIST_CHKPT_EN
    logic       b_chkpt, b_recover;
`endif

    int n_chk = 0;
    int n_err = 0;

    lsq_index_freelist u_a (
        .Clk(Clk), .Rest(Rest), .Rable(Rable), .Dout(Dout), .DoutValid(DoutValid),
        .PreOut(PreOut), .Wable(Wable), .Din(Din), .Clean(Clean), .Full(Full),
        .Empty(Empty), .Count(Count), .AlmostEmpty(AlmostEmpty), .PushErr(PushErr),
        .PopErr(PopErr)
`ifdef LSQ_FREELIST_CHKPT_EN
        , .Chkpt(Chkpt), .Recover(Recover)
`endif
    );

    lsq_index_freelist #(.DEPTH(3), .INIT_FULL(0)) u_b (
        .Clk(Clk), .Rest(Rest), .Rable(b_rable), .Dout(b_dout), .DoutValid(b_doutvalid),
        .PreOut(b_preout), .Wable(b_wable), .Din(b_din), .Clean(b_clean), .Full(b_full),
        .Empty(b_empty), .Count(b_count), .AlmostEmpty(b_ae), .PushErr(b_pusherr),
        .PopErr(b_poperr)
`ifdef LSQ_FREELIST_CHKPT_EN
        , .Chkpt(b_chkpt), .Recover(b_recover)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Rest = 1'b0;
        tick();
        Rest = 1'b1;
    endtask

    initial begin
        Rest = 1'b0; Rable = 0; Wable = 0; Clean = 0; Din = '0;
        b_rable = 0; b_wable = 0; b_clean = 0; b_din = '0;
`ifdef LSQ_FREELIST_CHKPT_EN
        Chkpt = 0; Recover = 0; b_chkpt = 0; b_recover = 0;
`endif
        tick();
        do_reset();

        // Reset state
        chk("rst_count", Count, 4);
        chk("rst_full", Full, 1);
        chk("rst_empty", Empty, 0);
        chk("rst_ae", AlmostEmpty, 0);
        chk("rst_dout", Dout, 0);
        chk("rst_dvld", DoutValid, 0);
        chk("rst_preout", PreOut, 0);
        chk("rst_errs", {PushErr, PopErr}, 0);
        chk("b_rst_count", b_count, 0);
        chk("b_rst_empty", b_empty, 1);
        chk("b_rst_ae", b_ae, 1);

        // Drain the preloaded sequence 0,4,8,12
        for (int k = 0; k < 4; k++) begin
            Rable = 1;
            chk("pop_preout", PreOut, 4 * k);
            tick();
            chk("pop_dout", Dout, 4 * k);
            chk("pop_dvld", DoutValid, 1);
            chk("pop_count", Count, 3 - k);
            if (k == 2) chk("pop_ae_at1", AlmostEmpty, 1);
        end
        chk("drain_empty", Empty, 1);
        chk("drain_ae", AlmostEmpty, 1);

        // Fifth pop on empty: error pulse, Dout held
        tick();
        chk("underflow_poperr", PopErr, 1);
        chk("underflow_dvld", DoutValid, 0);
        chk("underflow_dout", Dout, 12);
        chk("underflow_count", Count, 0);
        Rable = 0;
        tick();
        chk("poperr_pulse_end", PopErr, 0);

        // Empty with simultaneous pop+push: no bypass
        Rable = 1; Wable = 1; Din = 4'd9;
        tick();
        chk("nobypass_poperr", PopErr, 1);
        chk("nobypass_pusherr", PushErr, 0);
        chk("nobypass_count", Count, 1);
        Wable = 0;
        tick();
        chk("nobypass_dout", Dout, 9);
        chk("nobypass_dvld", DoutValid, 1);
        chk("nobypass_count0", Count, 0);
        Rable = 0;

        // Overflow rejected, then pop+push on full
        do_reset();
        Wable = 1; Din = 4'd5;
        tick();
        chk("ovf_pusherr", PushErr, 1);
        chk("ovf_count", Count, 4);
        Rable = 1;
        tick();
        chk("pp_dout", Dout, 0);
        chk("pp_count", Count, 4);
        chk("pp_pusherr", PushErr, 0);
        Wable = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("pp_drain", Dout, (k == 3) ? 5 : 4 * (k + 1));
        end
        Rable = 0;

        // Flush overrides same-cycle push/pop
        do_reset();
        Rable = 1;
        tick();
        tick();
        chk("pre_flush_dout", Dout, 4);
        Wable = 1; Din = 4'd3; Clean = 1;
        tick();
        chk("flush_count", Count, 4);
        chk("flush_preout", PreOut, 0);
        chk("flush_dvld", DoutValid, 0);
        chk("flush_errs", {PushErr, PopErr}, 0);
        chk("flush_dout_kept", Dout, 4);
        Rable = 0; Wable = 0; Clean = 0;

        // DEPTH=3 instance: fill, overflow, drain, wrap
        for (int k = 1; k <= 4; k++) begin
            b_wable = 1; b_din = 4'(k);
            tick();
            chk("b_push_err", b_pusherr, (k == 4) ? 1 : 0);
            chk("b_push_count", b_count, (k == 4) ? 3 : k);
        end
        chk("b_full", b_full, 1);
        b_wable = 0;
        b_rable = 1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("b_pop_dout", b_dout, k);
        end
        b_rable = 0;
        chk("b_drained", b_empty, 1);
        b_wable = 1; b_din = 4'd7;
        tick();
        b_wable = 0; b_rable = 1;
        tick();
        chk("b_wrap_dout", b_dout, 7);
        chk("b_wrap_dvld", b_doutvalid, 1);
        b_rable = 0;

`ifdef LSQ_FREELIST_CHKPT_EN
        // Checkpoint at full, pop three, roll back
        do_reset();
        Chkpt = 1;
        tick();
        Chkpt = 0; Rable = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("ck_pop", Dout, 4 * k);
        end
        Rable = 0; Recover = 1;
        tick();
        Recover = 0;
        chk("ck_rec_count", Count, 4);
        chk("ck_rec_preout", PreOut, 0);
        Rable = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("ck_replay", Dout, 4 * k);
        end
        Rable = 0;
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
